mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified instruction/data memory port between the IF stage (fetch) and MEM stage
//  (load/store) of the RV32I pipeline. Arbitrates, sequences a request/grant/response handshake
//  and drives per-requester stall signals into the hazard logic.
//  Sits between the core stage registers and the external memory/bus adapter.
// PARAMETERS
//  XLEN         32  address/data width
//  STARVE_LIMIT 4   consecutive D grants while I waits before I is forced to win (fair mode only)
// PORTS
//  clk        in  1     clock, all state on rising edge
//  rst_n      in  1     reset, asynchronous, active-low
//  i_req      in  1     fetch request; held with i_addr stable until i_done
//  i_addr     in  XLEN  fetch address
//  i_rdata    out XLEN  fetched word, valid when i_done
//  i_done     out 1     one-cycle completion pulse for fetch
//  i_stall    out 1     i_req & ~i_done
//  d_req      in  1     load/store request; held with d_* stable until d_done
//  d_we       in  1     1=store, 0=load
//  d_addr     in  XLEN  data address
//  d_wdata    in  XLEN  store data
//  d_wstrb    in  4     store byte strobes
//  d_rdata    out XLEN  load data, valid when d_done
//  d_done     out 1     one-cycle completion pulse for data
//  d_stall    out 1     d_req & ~d_done
//  mem_req    out 1     request to memory, held until mem_gnt
//  mem_we     out 1     write enable
//  mem_addr   out XLEN  registered address
//  mem_wdata  out XLEN  registered write data
//  mem_wstrb  out 4     registered strobes; forced 4'b0000 on reads
//  mem_gnt    in  1     memory accepted request this cycle
//  mem_rvalid in  1     response (read data or write ack), >=1 cycle after mem_gnt
//  mem_rdata  in  XLEN  read data, valid with mem_rvalid
// BEHAVIOUR
//  - FSM: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D. Exactly one transaction outstanding.
//  - IDLE: d_req -> latch d_* into mem_* regs, ISSUE_D; else i_req -> latch i_addr, mem_we=0,
//    ISSUE_I; else stay. Both requesting: D wins (older instruction) unless fair override.
//  - ISSUE_x: mem_req=1; mem_gnt -> WAIT_x. mem_rvalid in ISSUE_x is ignored.
//  - WAIT_x: mem_req=0; mem_rvalid -> x_done=1 (combinational), x_rdata=mem_rdata, -> IDLE.
//  - Next arbitration occurs in the IDLE cycle after completion (no back-to-back issue).
//  - Min latency: req seen cycle 0, mem_req cycle 1 with gnt, rvalid cycle 2 -> done cycle 2.
//  - i_rdata/d_rdata pass mem_rdata through; undefined outside done cycle (drive mem_rdata).
//  - Requester dropping req mid-transaction: transaction still completes; done pulse still issued.
//  - mem_rvalid in IDLE: ignored, no done pulse.
//  - Reset (any state, any time): state=IDLE, mem_req=0, mem_we=0, mem_addr/wdata=0,
//    mem_wstrb=0, starve counter=0; done=0; in-flight memory transaction abandoned.
//  - No alignment check; mem_addr is d_addr/i_addr verbatim.
// CONFIGURATION
//  ARB_FAIR_EN defined: counter (width $clog2(STARVE_LIMIT+1)) increments on each D issue while
//   i_req=1, clears on any I issue; when count==STARVE_LIMIT and both request, I wins.
//  ARB_FAIR_EN undefined: strict D-over-I priority, no counter; I may starve.
// STRUCTURE
//  - config.vh: `define state encodings (ARB_IDLE.. ARB_WAIT_D, 3-bit), XLEN default.
//  - Sub-module mem_arb_pick: combinational winner select (d_req, i_req, starve_hit) -> grant_d,
//    grant_i; top holds FSM, mem_* registers, counter.
// TESTING
//  1. i_req=1,i_addr=0x100; gnt at cycle1, rvalid=1,rdata=0x00500093 cycle2 -> i_done cycle2, i_rdata match.
//  2. i_req & d_req same cycle, d_we=1,d_addr=0x2000,wdata=0xDEADBEEF,wstrb=0xF -> store issued first;
//     fetch issued in IDLE after d_done; i_stall=1 throughout.
//  3. Load, mem_gnt withheld 3 cycles -> mem_req held, mem_addr stable; d_stall=1 until rvalid.
//  4. rst_n low while in WAIT_D -> mem_req=0 immediately, state IDLE; later rvalid gives no done.
//  5. Spurious mem_rvalid in IDLE and ISSUE_I -> no done pulse; read mem_wstrb==0.
//  6. ARB_FAIR_EN, STARVE_LIMIT=4, d_req & i_req held -> 4 D transactions then 1 I, repeat;
//     without macro -> only D served.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the unified memory port arbiter
package mem_port_arbiter_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_ISSUE_I = 3'd1,
        ARB_ISSUE_D = 3'd2,
        ARB_WAIT_I  = 3'd3,
        ARB_WAIT_D  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - combinational winner select between fetch and data requests
module mem_arb_pick (
    input  logic d_req,
    input  logic i_req,
    input  logic starve_hit,
    output logic grant_d,
    output logic grant_i
);

    // Data normally wins (older instruction); a saturated starve count hands the slot to fetch.
    always_comb begin
        grant_d = d_req & ~(starve_hit & i_req);
        grant_i = i_req & ~grant_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, one transaction in flight
// Optional fetch anti-starvation counter enabled by defining ARB_FAIR_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_done,
    output logic            i_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    logic       grant_d, grant_i, starve_hit;

    mem_arb_pick u_pick (
        .d_req      (d_req),
        .i_req      (i_req),
        .starve_hit (starve_hit),
        .grant_d    (grant_d),
        .grant_i    (grant_i)
    );

`ifdef ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (grant_i)
                starve_cnt <= '0;
            else if (grant_d && i_req && !starve_hit)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict priority: the limit never applies, the expression is constant false.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (grant_d)
                    state_nxt = ARB_ISSUE_D;
                else if (grant_i)
                    state_nxt = ARB_ISSUE_I;
            end
            ARB_ISSUE_I: begin
                mem_req = 1'b1;
                if (mem_gnt)
                    state_nxt = ARB_WAIT_I;
            end
            ARB_ISSUE_D: begin
                mem_req = 1'b1;
                if (mem_gnt)
                    state_nxt = ARB_WAIT_D;
            end
            ARB_WAIT_I: begin
                if (mem_rvalid) begin
                    i_done    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_WAIT_D: begin
                if (mem_rvalid) begin
                    d_done    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Request fields are captured once at arbitration and held stable through the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else if (state == ARB_IDLE) begin
            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_we ? d_wstrb : 4'b0000;
            end else if (grant_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_wstrb <= 4'b0000;
            end
        end
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_req, d_req, d_we;
    logic [XLEN-1:0] i_addr, d_addr, d_wdata;
    logic [3:0]      d_wstrb;
    logic [XLEN-1:0] i_rdata, d_rdata;
    logic            i_done, i_stall, d_done, d_stall;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wstrb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic            req;
        logic [XLEN-1:0] addr;
        logic            we;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
        logic            stable;
        logic            stalled;
        logic            early;
        logic            gi;
        logic            gd;
        logic [XLEN-1:0] rd;
    } obs_t;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Acts as the memory for one transaction, starting from an IDLE cycle with requests driven.
    task automatic serve(input int gdly, input int rdly, input logic [XLEN-1:0] rdata, output obs_t o);
        o.stable = 1'b1; o.stalled = 1'b1; o.early = 1'b0;
        step();
        mem_gnt = 1'b0;
        #1;
        o.req = mem_req; o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata; o.wstrb = mem_wstrb;
        for (int k = 0; k < gdly; k++) begin
            if (mem_req !== 1'b1 || mem_addr !== o.addr || mem_we !== o.we) o.stable = 1'b0;
            if (!(i_stall | d_stall)) o.stalled = 1'b0;
            if (i_done | d_done) o.early = 1'b1;
            step();
            #1;
        end
        mem_gnt = 1'b1;
        #1;
        if (mem_req !== 1'b1 || mem_addr !== o.addr) o.stable = 1'b0;
        step();
        mem_gnt = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            #1;
            if (i_done | d_done) o.early = 1'b1;
            if (mem_req !== 1'b0) o.stable = 1'b0;
            if (!(i_stall | d_stall)) o.stalled = 1'b0;
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        #1;
        o.gi = i_done;
        o.gd = d_done;
        o.rd = d_done ? d_rdata : i_rdata;
        step();
        mem_rvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        i_req = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got req=%0b we=%0b addr=%h wdata=%h wstrb=%h, want all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        step();
        step();
        checks++;
        if (mem_req !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_idle: got mem_req=%0b i_done=%0b d_done=%0b, want 0 0 0", mem_req, i_done, d_done);
        end
        rst_n = 1'b1;
        i_req = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        obs_t o;
        apply_reset();
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        checks++;
        if (i_stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle0: got i_stall=%0b mem_req=%0b, want 1 0", i_stall, mem_req);
        end
        serve(0, 0, 32'h0050_0093, o);
        i_req = 1'b0;
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h100 || o.we !== 1'b0 || o.wstrb !== 4'h0) begin
            errors++;
            $display("FAIL fetch_issue: got req=%0b addr=%h we=%0b wstrb=%h, want 1 00000100 0 0", o.req, o.addr, o.we, o.wstrb);
        end
        checks++;
        if (o.gi !== 1'b1 || o.gd !== 1'b0 || o.rd !== 32'h0050_0093 || o.early !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: got i_done=%0b d_done=%0b rdata=%h early=%0b, want 1 0 00500093 0", o.gi, o.gd, o.rd, o.early);
        end
    endtask

    task automatic test_priority();
        obs_t o;
        apply_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        serve(1, 1, 32'h0, o);
        d_req = 1'b0;
        checks++;
        if (o.gd !== 1'b1 || o.gi !== 1'b0 || o.we !== 1'b1 || o.addr !== 32'h2000 ||
            o.wdata !== 32'hDEAD_BEEF || o.wstrb !== 4'hF) begin
            errors++;
            $display("FAIL store_first: got d_done=%0b i_done=%0b we=%0b addr=%h wdata=%h wstrb=%h, want 1 0 1 00002000 deadbeef f",
                     o.gd, o.gi, o.we, o.addr, o.wdata, o.wstrb);
        end
        checks++;
        if (i_stall !== 1'b1 || o.stalled !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stalled: got i_stall=%0b stalled_throughout=%0b, want 1 1", i_stall, o.stalled);
        end
        serve(0, 0, 32'h1234_5678, o);
        i_req = 1'b0;
        checks++;
        if (o.gi !== 1'b1 || o.addr !== 32'h200 || o.we !== 1'b0 || o.rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_after_store: got i_done=%0b addr=%h we=%0b rdata=%h, want 1 00000200 0 12345678", o.gi, o.addr, o.we, o.rd);
        end
    endtask

    task automatic test_gnt_wait();
        obs_t o;
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3004; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hA;
        serve(3, 2, 32'hCAFE_F00D, o);
        d_req = 1'b0;
        checks++;
        if (o.stable !== 1'b1 || o.addr !== 32'h3004 || o.wstrb !== 4'h0 || o.stalled !== 1'b1) begin
            errors++;
            $display("FAIL load_gnt_wait: got stable=%0b addr=%h wstrb=%h stalled=%0b, want 1 00003004 0 1", o.stable, o.addr, o.wstrb, o.stalled);
        end
        checks++;
        if (o.gd !== 1'b1 || o.early !== 1'b0 || o.rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL load_done: got d_done=%0b early=%0b rdata=%h, want 1 0 cafef00d", o.gd, o.early, o.rd);
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: got mem_req=%0b mem_addr=%h d_done=%0b, want 0 0 0", mem_req, mem_addr, d_done);
        end
        step();
        rst_n = 1'b1;
        d_req = 1'b0;
        #1;
        checks++;
        if (d_done !== 1'b0 || i_done !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid_after_reset: got d_done=%0b i_done=%0b, want 0 0", d_done, i_done);
        end
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_spurious();
        apply_reset();
        mem_rvalid = 1'b1;
        #1;
        checks++;
        if (i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_in_idle: got i_done=%0b d_done=%0b, want 0 0", i_done, d_done);
        end
        i_req = 1'b1; i_addr = 32'h44;
        step();
        #1;
        checks++;
        if (i_done !== 1'b0 || mem_req !== 1'b1 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_in_issue: got i_done=%0b mem_req=%0b wstrb=%h we=%0b, want 0 1 0 0", i_done, mem_req, mem_wstrb, mem_we);
        end
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A_0001;
        #1;
        checks++;
        if (i_done !== 1'b1 || i_rdata !== 32'h5A5A_0001) begin
            errors++;
            $display("FAIL fetch_after_spurious: got i_done=%0b rdata=%h, want 1 5a5a0001", i_done, i_rdata);
        end
        step();
        i_req = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_fairness();
        obs_t o;
        int   cnt;
        logic exp_i;
        apply_reset();
        cnt = 0;
        i_req = 1'b1; i_addr = 32'h800;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        for (int n = 0; n < 10; n++) begin
            exp_i = FAIR && (cnt == LIMIT);
            serve(0, 0, 32'(n), o);
            checks++;
            if (o.gi !== exp_i || o.gd !== !exp_i) begin
                errors++;
                $display("FAIL fairness_txn%0d: got i_done=%0b d_done=%0b, want %0b %0b", n, o.gi, o.gd, exp_i, !exp_i);
            end
            cnt = exp_i ? 0 : cnt + 1;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        obs_t            o;
        int              cnt;
        logic            exp_i, exp_we;
        logic [XLEN-1:0] rdata, exp_addr;
        logic [3:0]      exp_wstrb;
        apply_reset();
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (!i_req) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
            end
            if (!d_req) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(1, 15));
            end
            if (!i_req && !d_req) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            exp_i     = i_req && (!d_req || (FAIR && cnt == LIMIT));
            exp_addr  = exp_i ? i_addr : d_addr;
            exp_we    = !exp_i && d_we;
            exp_wstrb = exp_we ? d_wstrb : 4'h0;
            rdata     = $urandom;
            serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdata, o);
            checks++;
            if (o.gi !== exp_i || o.gd !== !exp_i || o.rd !== rdata || o.early !== 1'b0) begin
                errors++;
                $display("FAIL rand_done%0d: got i_done=%0b d_done=%0b rdata=%h early=%0b, want %0b %0b %h 0",
                         n, o.gi, o.gd, o.rd, o.early, exp_i, !exp_i, rdata);
            end
            checks++;
            if (o.addr !== exp_addr || o.we !== exp_we || o.wstrb !== exp_wstrb || o.stable !== 1'b1 ||
                (exp_we && o.wdata !== d_wdata)) begin
                errors++;
                $display("FAIL rand_issue%0d: got addr=%h we=%0b wstrb=%h wdata=%h stable=%0b, want %h %0b %h %h 1",
                         n, o.addr, o.we, o.wstrb, o.wdata, o.stable, exp_addr, exp_we, exp_wstrb, d_wdata);
            end
            if (exp_i) begin
                cnt = 0;
                i_req = 1'b0;
            end else begin
                if (i_req) cnt++;
                d_req = 1'b0;
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_gnt_wait();
        test_reset_in_wait();
        test_spurious();
        test_fairness();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
